sar_logic: RTL and testbench

- Successive-approximation controller for the time-domain SAR ADC; sits downstream of the comparator clock generator.
- Each conversion runs three steps:
  - issues a sampling window;
  - strobes the comparator once per bit, MSB first;
  - consumes the comparator decision/ready handshake and builds the trial DAC code.
- Delivers the final N-bit code with a one-cycle done pulse.
- Flags comparator timeouts, so a stuck or metastable comparator cannot hang the converter.

---
 rtl/sar_logic.sv | 150 +++++++++++++++
 tb/tb_sar_logic.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sar_logic.sv
// Successive-approximation register controller: samples, strobes the comparator MSB-first,
// builds the trial DAC code and publishes the result with a one-cycle done pulse.
module sar_logic #(
  parameter int N             = 8,
  parameter int SAMPLE_CYCLES = 2,
  parameter int TIMEOUT       = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         cmp_rdy,
  input  logic         cmp_out,
  output logic         sample,
  output logic         cmp_en,
  output logic [N-1:0] dac_code,
  output logic [N-1:0] dout,
  output logic         done,
  output logic         busy,
  output logic         timeout_err
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(SAMPLE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_STROBE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [SW-1:0]  scnt_q, scnt_d;
  logic [N-1:0]   code_q, code_d;
  logic [N-1:0]   dout_q, dout_d;
  logic           done_q, done_d;
  logic           terr_q, terr_d;
  logic           decide;
  logic           bit_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      tmo_q   <= '0;
      scnt_q  <= '0;
      code_q  <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      scnt_q  <= scnt_d;
      code_q  <= code_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    scnt_d  = scnt_q;
    code_d  = code_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    terr_d  = terr_q;
    decide  = 1'b0;
    bit_val = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SAMPLE;
          terr_d  = 1'b0;
          code_d  = '0;
          idx_d   = IW'(N - 1);
          scnt_d  = '0;
        end
      end

      S_SAMPLE: begin
        if (scnt_q == SW'(SAMPLE_CYCLES - 1)) begin
          code_d[N-1] = 1'b1;
          state_d     = S_STROBE;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end

      S_STROBE: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // A real decision on the expiry cycle takes priority over the forced zero.
        if (cmp_rdy) begin
          decide  = 1'b1;
          bit_val = cmp_out;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          decide  = 1'b1;
          bit_val = 1'b0;
          terr_d  = 1'b1;
        end else if (tmo_q != TW'(TIMEOUT)) begin
          tmo_d = tmo_q + 1'b1;
        end

        if (decide) begin
          code_d[idx_q] = bit_val;
          if (idx_q != '0) begin
            code_d[idx_q - 1'b1] = 1'b1;
            idx_d                = idx_q - 1'b1;
            state_d              = S_STROBE;
          end else begin
            dout_d  = code_d;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes decode straight from the state register, so they cannot overlap.
  assign sample      = (state_q == S_SAMPLE);
  assign cmp_en      = (state_q == S_STROBE);
  assign busy        = (state_q != S_IDLE);
  assign dac_code    = code_q;
  assign dout        = dout_q;
  assign done        = done_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_sar_logic.sv
// Directed bench for sar_logic with a behavioural comparator whose response delay is set per bit.
module tb_sar_logic;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         cmp_rdy;
  logic         cmp_out;
  logic         sample;
  logic         cmp_en;
  logic [N-1:0] dac_code;
  logic [N-1:0] dout;
  logic         done;
  logic         busy;
  logic         timeout_err;

  sar_logic #(.N(N), .SAMPLE_CYCLES(2), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cmp_rdy     (cmp_rdy),
    .cmp_out     (cmp_out),
    .sample      (sample),
    .cmp_en      (cmp_en),
    .dac_code    (dac_code),
    .dout        (dout),
    .done        (done),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Comparator model knobs: dly[b] = WAIT cycle on which bit b is answered (0 = never).
  logic [N-1:0] vin;
  int           dly [N];
  logic         glitch;

  // Monitor state
  int         pcnt, scnt, ovl, cur_bit, wcnt;
  logic [N-1:0] trials [N];

  always @(posedge clk or negedge clk) begin
    if (clk) begin
      if (rst || (start && !busy)) begin
        pcnt    = 0;
        scnt    = 0;
        ovl     = 0;
        cur_bit = -1;
        wcnt    = 100;
      end
    end else begin
      if (cmp_en) begin
        pcnt++;
        if (pcnt <= N) trials[pcnt-1] = dac_code;
        cur_bit = N - pcnt;
        wcnt    = 0;
        cmp_rdy = glitch;
        cmp_out = 1'b0;
      end else begin
        wcnt++;
        cmp_rdy = (cur_bit >= 0) && (cur_bit < N) && (dly[cur_bit] != 0) && (wcnt == dly[cur_bit]);
        cmp_out = cmp_rdy ? (vin >= dac_code) : !(vin >= dac_code);
      end
      if (sample) scnt++;
      if (sample && cmp_en) ovl++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge while the DUT is idle; returns at the negedge of the done cycle.
  task automatic run_conv(input logic [N-1:0] v, input logic [N-1:0] exp_dout, input int exp_lat,
                          input logic exp_tmo, input logic spam, input string tag);
    int cyc;
    vin   = v;
    start = 1'b1;
    @(posedge clk);
    #1 start = spam;
    cyc = 0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk({tag, "_tmo_clr"}, {31'd0, timeout_err}, 32'd0);
      if (done) break;
      start = spam;
    end
    start = 1'b0;
    chk({tag, "_lat"}, cyc, exp_lat);
    chk({tag, "_dout"}, {24'd0, dout}, {24'd0, exp_dout});
    chk({tag, "_tmo"}, {31'd0, timeout_err}, {31'd0, exp_tmo});
    chk({tag, "_strobes"}, pcnt, N);
    chk({tag, "_samples"}, scnt, 2);
    chk({tag, "_overlap"}, ovl, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
  endtask

  logic [N-1:0] exp_trials [N];
  int           extra_done;

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    vin    = '0;
    glitch = 1'b0;
    for (int i = 0; i < N; i++) dly[i] = 1;
    exp_trials = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {11'd0, sample, cmp_en, done, busy, timeout_err, dac_code, dout}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_conv(8'hA5, 8'hA5, 19, 1'b0, 1'b0, "a5");
    for (int i = 0; i < N; i++) chk($sformatf("a5_trial%0d", i), {24'd0, trials[i]}, {24'd0, exp_trials[i]});
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    run_conv(8'h00, 8'h00, 19, 1'b0, 1'b0, "zero");
    @(negedge clk);
    run_conv(8'hFF, 8'hFF, 19, 1'b0, 1'b0, "full");

    // Comparator never answers bit 7.
    dly[7] = 0;
    @(negedge clk);
    run_conv(8'hFF, 8'h7F, 34, 1'b1, 1'b0, "hang");
    @(negedge clk);
    chk("tmo_sticky", {31'd0, timeout_err}, 32'd1);

    // Answer lands on the same cycle the timeout expires.
    dly[7] = 16;
    run_conv(8'hFF, 8'hFF, 34, 1'b0, 1'b0, "late");
    dly[7] = 1;

    // Reset in the middle of the sampling window.
    @(negedge clk);
    vin   = 8'h33;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("mid_sample", {31'd0, sample}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async", {11'd0, sample, cmp_en, done, busy, timeout_err, dac_code, dout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_conv(8'h5A, 8'h5A, 19, 1'b0, 1'b0, "post_rst");

    // cmp_rdy with a wrong decision during every STROBE must be ignored.
    glitch = 1'b1;
    @(negedge clk);
    run_conv(8'hFF, 8'hFF, 19, 1'b0, 1'b0, "glitch");
    glitch = 1'b0;

    // start held high throughout the conversion.
    @(negedge clk);
    run_conv(8'h3C, 8'h3C, 19, 1'b0, 1'b1, "spam");
    extra_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    chk("spam_one_done", extra_done, 0);
    chk("spam_idle", {31'd0, busy}, 32'd0);

    // Start in the IDLE cycle right after DONE.
    @(negedge clk);
    run_conv(8'hC3, 8'hC3, 19, 1'b0, 1'b0, "b2b_a");
    @(negedge clk);
    run_conv(8'h81, 8'h81, 19, 1'b0, 1'b0, "b2b_b");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
